jtag_host_seq: RTL
==================

# jtag_host_seq

Bus-side JTAG host sequencer that sits directly upstream of the TAP top module and drives its TCK/TMS/TDI pins while capturing TDO. A single request (IR or DR scan, length, write data) runs a complete Run-Test/Idle → Shift → Update → Run-Test/Idle walk. TCK is derived from the system clock by a programmable divider. The block also issues the TMS-high TAP reset sequence automatically after reset and on demand.

## Interface
- CLK_DIV, 2: system clocks per TCK half-period (≥1)
- MAX_LEN, 16: maximum scan length in bits; LW = $clog2(MAX_LEN+1)

- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- START  in  1  request strobe; accepted when BUSY=0
- IS_IR  in  1  1 = IR scan, 0 = DR scan (sampled with START)
- LEN  in  LW  shift length in bits (sampled with START)
- WDATA  in  MAX_LEN  shift-in data, LSB shifted first
- TAP_RST  in  1  request TAP reset sequence; accepted when BUSY=0, priority over START
- BUSY  out  1  sequence in progress
- DONE  out  1  one-CLK pulse at scan completion
- RDATA  out  MAX_LEN  captured TDO bits, right-aligned, bit 0 = first captured
- TCK_O  out  1  JTAG test clock
- TMS_O  out  1  JTAG mode select
- TDI_O  out  1  JTAG data out to TAP
- TDO_I  in  1  JTAG data from TAP

## Operation
- States: RST_SEQ, IDLE, HEAD, SHIFT, TAIL, FIN.
- TCK period = CLK_DIV CLK cycles low then CLK_DIV high; TCK_O rests low when idle. TMS_O/TDI_O update on entry to each low phase; TDO_I is registered on the CLK edge where TCK_O goes high.
- RST_SEQ: 6 TCK periods with TMS = 1,1,1,1,1,0 → TAP in Run-Test/Idle. Entered after RST_N release and on TAP_RST. No DONE pulse.
- HEAD: IR → TMS 1,1,0,0; DR → TMS 1,0,0. TDI_O = 0.
- SHIFT: LEN periods, TDI_O = WDATA[i], TMS = 0 except the last bit (TMS = 1 → Exit1). TDO sampled on bit i's rising edge → RDATA[i]; bits ≥ LEN cleared to 0.
- TAIL: TMS 1 (Update), 0 (Run-Test/Idle). TDI_O = 0.
- FIN: one CLK, DONE=1, BUSY→0, RDATA valid and held until the next accepted scan.
- Total TCK periods: IR = LEN+6, DR = LEN+5.
- LEN = 0: accepted, no TCK edges, DONE pulses the cycle after acceptance, RDATA = 0.
- LEN > MAX_LEN: clamped to MAX_LEN.
- START or TAP_RST while BUSY: ignored, not queued.
- START and TAP_RST in the same cycle: TAP_RST wins, START dropped.

## Timing
- Reset values: BUSY=1 (RST_SEQ pending), DONE=0, RDATA=0, TCK_O=0, TMS_O=1, TDI_O=0.
- First CLK after RST_N deasserts: RST_SEQ starts; BUSY falls after 12·CLK_DIV cycles.
- Request accepted on edge k: BUSY=1 from k+1, first low phase begins at k+1. DONE=1 at k+1+N·2·CLK_DIV, where N = number of TCK periods. BUSY=0 in the same cycle.
- RST_N assertion mid-scan: all outputs take their reset values immediately. The scan is lost, no DONE. RST_SEQ reruns after release.
- Back-to-back: START may be asserted in the DONE cycle (BUSY=0), and the next scan begins one cycle later.

## Test plan
- Reset release, CLK_DIV=2 → 6 TCK rising edges with TMS 1,1,1,1,1,0; BUSY falls 24 cycles after release; DONE never pulses.
- IR scan, WDATA=4'hF, LEN=4 → TMS on rising edges 1,1,0,0,0,0,0,1,1,0; TDI=1 on the 4 shift edges; DONE exactly 41 cycles after acceptance (CLK_DIV=2).
- DR scan, LEN=10, WDATA=10'b1000000100, TDO_I from a 1-bit bypass model (TDI registered on rising TCK, driven on falling) → RDATA[9:0]=10'b0000001000; RDATA[15:10]=0.
- START pulsed while BUSY, and LEN=0 → busy START ignored with the TCK count unchanged; LEN=0 gives DONE on the next cycle, no TCK edge, RDATA=0.
- RST_N pulsed low during the 3rd shift bit → outputs at reset values in the same cycle; no DONE; a full 6-period RST_SEQ follows release.
- LEN=31 with MAX_LEN=16, DR scan → exactly 21 TCK periods; 16 bits shifted; TAP_RST+START together → only the reset sequence runs.

Source files
------------

// File: rtl/jtag_host_seq_if.sv
`default_nettype none
// ============================================================================
// jtag_host_seq_if
// Request/response bus and JTAG pin bundle for the JTAG host sequencer.
// Revision: 1.0
// ============================================================================
interface jtag_host_seq_if #(
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) ();
  logic               start;
  logic               is_ir;
  logic [LW-1:0]      len;
  logic [MAX_LEN-1:0] wdata;
  logic               tap_rst;
  logic               busy;
  logic               done;
  logic [MAX_LEN-1:0] rdata;
  logic               tck_o;
  logic               tms_o;
  logic               tdi_o;
  logic               tdo_i;

  modport master (
    output start, is_ir, len, wdata, tap_rst, tdo_i,
    input  busy, done, rdata, tck_o, tms_o, tdi_o
  );

  modport slave (
    input  start, is_ir, len, wdata, tap_rst, tdo_i,
    output busy, done, rdata, tck_o, tms_o, tdi_o
  );
endinterface
`default_nettype wire

// File: rtl/jtag_host_seq.sv
`default_nettype none
// ============================================================================
// jtag_host_seq
// Runs one IR/DR scan (Idle -> Shift -> Update -> Idle) or a TAP reset walk
// on the JTAG pins, with TCK divided down from the system clock.
// Revision: 1.0
// ============================================================================
module jtag_host_seq #(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 16,
  parameter int LW      = $clog2(MAX_LEN + 1)
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  jtag_host_seq_if.slave    bus
);

  localparam int                  c_cnt_w    = (CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int                  c_sw       = (LW > 3) ? LW : 3;
  localparam logic [c_cnt_w-1:0]  c_rise_cnt = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_cnt_w-1:0]  c_last_cnt = c_cnt_w'(2 * CLK_DIV - 1);
  localparam logic [LW-1:0]       c_max_len  = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    ST_RST_SEQ = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HEAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_TAIL    = 3'd4,
    ST_FIN     = 3'd5
  } state_t;

  state_t             r_state, w_state;
  logic [c_cnt_w-1:0] r_cnt, w_cnt;
  logic [c_sw-1:0]    r_step, w_step;
  logic               r_ir, w_ir;
  logic [LW-1:0]      r_len, w_len;
  logic [MAX_LEN-1:0] r_wdata, w_wdata;
  logic               r_tck, w_tck;
  logic               r_tms, w_tms;
  logic               r_tdi, w_tdi;
  logic               r_busy, w_busy;
  logic               r_done, w_done;
  logic [MAX_LEN-1:0] r_rdata, w_rdata;

  logic               w_accept_rst;
  logic               w_accept_scan;
  logic [LW-1:0]      w_len_in;
  logic [c_sw-1:0]    w_head_last;
  logic [c_sw-1:0]    w_shift_last;

  assign w_accept_rst  = bus.tap_rst & ~r_busy;
  assign w_accept_scan = bus.start & ~bus.tap_rst & ~r_busy;
  assign w_len_in      = (bus.len > c_max_len) ? c_max_len : bus.len;
  assign w_head_last   = r_ir ? c_sw'(3) : c_sw'(2);
  assign w_shift_last  = c_sw'(r_len) - c_sw'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RST_SEQ;
      r_cnt   <= '0;
      r_step  <= '0;
      r_ir    <= 1'b0;
      r_len   <= '0;
      r_wdata <= '0;
      r_tck   <= 1'b0;
      r_tms   <= 1'b1;
      r_tdi   <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_step  <= w_step;
      r_ir    <= w_ir;
      r_len   <= w_len;
      r_wdata <= w_wdata;
      r_tck   <= w_tck;
      r_tms   <= w_tms;
      r_tdi   <= w_tdi;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rdata <= w_rdata;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_step  = r_step;
    w_ir    = r_ir;
    w_len   = r_len;
    w_wdata = r_wdata;
    w_tck   = r_tck;
    w_tms   = r_tms;
    w_tdi   = r_tdi;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_rdata = r_rdata;

    case (r_state)
      ST_IDLE, ST_FIN: begin
        if (w_accept_rst) begin
          w_state = ST_RST_SEQ;
          w_cnt   = '0;
          w_step  = '0;
          w_tck   = 1'b0;
          w_tms   = 1'b1;
          w_tdi   = 1'b0;
          w_busy  = 1'b1;
        end else if (w_accept_scan) begin
          w_ir    = bus.is_ir;
          w_len   = w_len_in;
          w_wdata = bus.wdata;
          w_rdata = '0;
          w_cnt   = '0;
          w_step  = '0;
          if (w_len_in == '0) begin
            // Zero-length scan: no pin activity, complete immediately.
            w_state = ST_FIN;
            w_done  = 1'b1;
          end else begin
            w_state = ST_HEAD;
            w_tck   = 1'b0;
            w_tms   = 1'b1;
            w_tdi   = 1'b0;
            w_busy  = 1'b1;
          end
        end else if (r_state == ST_FIN) begin
          w_state = ST_IDLE;
        end
      end

      ST_RST_SEQ, ST_HEAD, ST_SHIFT, ST_TAIL: begin
        if (r_cnt == c_rise_cnt) begin
          w_tck = 1'b1;
          w_cnt = r_cnt + c_cnt_w'(1);
          if (r_state == ST_SHIFT)
            w_rdata = r_rdata | (MAX_LEN'(bus.tdo_i) << r_step);
        end else if (r_cnt == c_last_cnt) begin
          // End of a TCK period: set up TMS/TDI for the next low phase.
          w_tck  = 1'b0;
          w_cnt  = '0;
          w_tdi  = 1'b0;
          w_step = r_step + c_sw'(1);
          case (r_state)
            ST_RST_SEQ: begin
              if (r_step == c_sw'(5)) begin
                w_state = ST_IDLE;
                w_step  = '0;
                w_busy  = 1'b0;
              end else begin
                w_tms = (r_step != c_sw'(4));
              end
            end
            ST_HEAD: begin
              if (r_step == w_head_last) begin
                w_state = ST_SHIFT;
                w_step  = '0;
                w_tms   = (r_len == LW'(1));
                w_tdi   = r_wdata[0];
              end else begin
                w_tms = r_ir && (r_step == '0);
              end
            end
            ST_SHIFT: begin
              if (r_step == w_shift_last) begin
                w_state = ST_TAIL;
                w_step  = '0;
                w_tms   = 1'b1;
              end else begin
                w_wdata = r_wdata >> 1;
                w_tdi   = r_wdata[1];
                w_tms   = ((r_step + c_sw'(1)) == w_shift_last);
              end
            end
            default: begin
              if (r_step == c_sw'(1)) begin
                w_state = ST_FIN;
                w_step  = '0;
                w_busy  = 1'b0;
                w_done  = 1'b1;
              end else begin
                w_tms = 1'b0;
              end
            end
          endcase
        end else begin
          w_cnt = r_cnt + c_cnt_w'(1);
        end
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  assign bus.busy  = r_busy;
  assign bus.done  = r_done;
  assign bus.rdata = r_rdata;
  assign bus.tck_o = r_tck;
  assign bus.tms_o = r_tms;
  assign bus.tdi_o = r_tdi;

endmodule
`default_nettype wire
